if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC selection mux.
- Owns the PC register, supplies PC+4 (NPC) back to the mux, and issues instruction-memory reads.
- Loads the IF/ID pipeline register, with stall support, flush on taken Jump/Branch, and a one-entry skid buffer so a fetch returned during a stall is not lost.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on bubble or flush.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC_Result  in  32  next-PC from the PC mux.
- Redirect  in  1  Jump or taken Branch this cycle; flushes fetch.
- Stall  in  1  hazard unit: ID not accepting; IF/ID must hold.
- IMem_Req  out  1  read request.
- IMem_Addr  out  32  read address; always equal to PC.
- IMem_Ack  in  1  valid only when IMem_Req=1; IMem_Rdata is the word at this cycle's IMem_Addr.
- IMem_Rdata  in  32  instruction word.
- PC  out  32  current fetch PC.
- NPC  out  32  PC+4, combinational, to the PC mux.
- IF_ID_PC  out  32  PC of instruction in IF/ID.
- IF_ID_NPC  out  32  IF_ID_PC+4.
- IF_ID_Instr  out  32  instruction in IF/ID.
- IF_ID_Valid  out  1  IF/ID holds a real instruction.
- Fetch_Busy  out  1  IMem_Req & ~IMem_Ack.
- Bubble_Count  out  CNT_W  saturating count of bubbles caused by missing ack.

Behaviour:
- Reset (asynchronous, immediate, no clock needed):
  - PC=RESET_PC, state=S_REQ.
  - IF_ID_Valid=0, IF_ID_Instr=NOP_INSTR, IF_ID_PC=IF_ID_NPC=0.
  - Skid buffer empty, Bubble_Count=0.
  - IMem_Req=0 while rst=1; first request in the first cycle after rst deasserts.
- States:
  - S_REQ: IMem_Req=1.
  - S_HOLD: skid buffer full, IMem_Req=0.
- Memory contract: ack is same-cycle with the address. A request may be withdrawn or re-addressed in any cycle without a drain. At most one word is accepted per cycle.
- "Accept" means IMem_Ack=1 in S_REQ with Redirect=0. On accept, PC <= PC_Result (= NPC absent redirect).
- S_REQ, Redirect=0:
  - Ack and Stall=0: IF/ID <= {PC, PC+4, IMem_Rdata, Valid=1}. Stay in S_REQ.
  - Ack and Stall=1: IF/ID holds; skid <= {PC, IMem_Rdata}; go to S_HOLD.
  - No ack and Stall=0: IF/ID <= bubble {Valid=0, Instr=NOP_INSTR, PC/NPC unchanged}; Bubble_Count+1, saturating at all-ones; PC holds.
  - No ack and Stall=1: IF/ID and PC hold.
- S_HOLD, Redirect=0:
  - Stall=1: everything holds.
  - Stall=0: IF/ID <= {skid PC, skid PC+4, skid instr, Valid=1}; skid empties; go to S_REQ. The request resumes the next cycle at the already-advanced PC.
- Redirect=1, any state, highest priority over Stall and Ack:
  - PC <= PC_Result.
  - IF/ID <= bubble (Valid=0, Instr=NOP_INSTR).
  - Skid cleared; state <= S_REQ.
  - Any same-cycle IMem_Rdata is discarded.
  - Bubble_Count is not incremented (flush is not a fetch bubble).
- Combinational outputs:
  - NPC = PC + 32'd4, with wrap-around modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - IF_ID_NPC = IF_ID_PC + 4, same wrap rule.
- Fetch_Busy = IMem_Req & ~IMem_Ack.
- Latency: an instruction acked at cycle N with no stall is visible in IF/ID after the edge ending cycle N. Zero-bubble throughput is 1 instruction/cycle.

Test Plan:
- Reset release, IMem_Ack=1 every cycle, Stall=0, PC_Result=NPC -> IF_ID_PC = 0x3000, 0x3004, 0x3008 on consecutive edges; IF_ID_Valid=1; Bubble_Count=0.
- Ack withheld 2 cycles at PC=0x3004 -> two IF/ID bubbles (Valid=0, Instr=0x0); PC stays 0x3004; Bubble_Count=2; Fetch_Busy=1 in those cycles.
- Stall=1 in the cycle 0x3008 is acked -> IF/ID keeps 0x3004; skid holds 0x3008; IMem_Req=0; PC=0x300C. Stall drops -> next edge IF_ID_PC=0x3008, Valid=1; request at 0x300C the following cycle.
- Redirect=1, PC_Result=0x3100, coincident with Ack=1 and Stall=1 -> IF_ID_Valid=0, Instr=0x0; PC=0x3100; skid empty; next IMem_Addr=0x3100.
- Redirect to 0x3200 while in S_HOLD -> skid contents never reach IF/ID; state S_REQ; first valid IF_ID_PC=0x3200.
- rst asserted mid-fetch between clock edges -> PC=0x3000, IF_ID_Valid=0, IMem_Req=0, Bubble_Count=0 immediately; force 0xFFFF bubbles -> Bubble_Count stays 0xFFFF.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// loads the IF/ID pipeline register. A one-entry skid buffer keeps a word that
// is acked while ID is stalled. A redirect (jump or taken branch) flushes the
// fetch and overrides both stall and ack.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC_Result,
  input  logic             Redirect,
  input  logic             Stall,
  output logic             IMem_Req,
  output logic [31:0]      IMem_Addr,
  input  logic             IMem_Ack,
  input  logic [31:0]      IMem_Rdata,
  output logic [31:0]      PC,
  output logic [31:0]      NPC,
  output logic [31:0]      IF_ID_PC,
  output logic [31:0]      IF_ID_NPC,
  output logic [31:0]      IF_ID_Instr,
  output logic             IF_ID_Valid,
  output logic             Fetch_Busy,
  output logic [CNT_W-1:0] Bubble_Count
);

  // S_REQ: requesting from memory. S_HOLD: skid buffer full, request paused.
  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic        req;
  logic        ack_seen;

  // Request is forced low while reset is held so nothing is fetched before
  // the first cycle after reset release.
  always_comb begin
    req      = (state_q == S_REQ) && !rst;
    // Ack is only meaningful while a request is outstanding.
    ack_seen = req && IMem_Ack;
  end

  // Next-state: PC, IF/ID register, skid buffer, FSM and bubble counter.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    bubble_cnt_d  = bubble_cnt_q;

    if (Redirect) begin
      // Flush: any returned word is dropped and the skid buffer is emptied.
      // A flush is not counted as a fetch bubble.
      pc_d          = PC_Result;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      skid_pc_d     = '0;
      skid_instr_d  = NOP_INSTR;
      state_d       = S_REQ;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (ack_seen) begin
            pc_d = PC_Result;
            if (!Stall) begin
              if_id_pc_d    = pc_q;
              if_id_instr_d = IMem_Rdata;
              if_id_valid_d = 1'b1;
            end else begin
              // ID is busy: park the word until the stall clears.
              skid_pc_d    = pc_q;
              skid_instr_d = IMem_Rdata;
              state_d      = S_HOLD;
            end
          end else if (!Stall) begin
            // Memory did not answer: push a bubble, keep PC for a retry.
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            if (bubble_cnt_q != {CNT_W{1'b1}}) begin
              bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            if_id_pc_d    = skid_pc_q;
            if_id_instr_d = skid_instr_q;
            if_id_valid_d = 1'b1;
            skid_pc_d     = '0;
            skid_instr_d  = NOP_INSTR;
            state_d       = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      skid_pc_q     <= '0;
      skid_instr_q  <= NOP_INSTR;
      bubble_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  // Output drive; the +4 adders wrap modulo 2^32.
  always_comb begin
    IMem_Req     = req;
    IMem_Addr    = pc_q;
    PC           = pc_q;
    NPC          = pc_q + 32'd4;
    IF_ID_PC     = if_id_pc_q;
    IF_ID_NPC    = if_id_pc_q + 32'd4;
    IF_ID_Instr  = if_id_instr_q;
    IF_ID_Valid  = if_id_valid_q;
    Fetch_Busy   = req && !IMem_Ack;
    Bubble_Count = bubble_cnt_q;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a table of per-cycle vectors with
// hand-computed expectations, plus async-reset and counter-saturation sequences.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_Result;
  logic        Redirect;
  logic        Stall;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Rdata;
  logic [31:0] PC;
  logic [31:0] NPC;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_NPC;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
  logic        Fetch_Busy;
  logic [15:0] Bubble_Count;

  int pass_cnt = 0;
  int total    = 0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_3000),
    .NOP_INSTR(32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PC_Result   (PC_Result),
    .Redirect    (Redirect),
    .Stall       (Stall),
    .IMem_Req    (IMem_Req),
    .IMem_Addr   (IMem_Addr),
    .IMem_Ack    (IMem_Ack),
    .IMem_Rdata  (IMem_Rdata),
    .PC          (PC),
    .NPC         (NPC),
    .IF_ID_PC    (IF_ID_PC),
    .IF_ID_NPC   (IF_ID_NPC),
    .IF_ID_Instr (IF_ID_Instr),
    .IF_ID_Valid (IF_ID_Valid),
    .Fetch_Busy  (Fetch_Busy),
    .Bubble_Count(Bubble_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        red;
    logic        stall;
    logic        ack;
    logic [31:0] pc_res;
    logic [31:0] rdata;
    // Expected before the edge (combinational).
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    // Expected after the edge.
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic apply(input vec_t v, input int idx);
    string s;
    @(negedge clk);
    rst        = 1'b0;
    Redirect   = v.red;
    Stall      = v.stall;
    IMem_Ack   = v.ack;
    PC_Result  = v.pc_res;
    IMem_Rdata = v.rdata;
    #1;
    s = $sformatf("v%0d", idx);
    chk({s, ".req"},  {31'd0, IMem_Req},   {31'd0, v.e_req});
    chk({s, ".addr"}, IMem_Addr,           v.e_addr);
    chk({s, ".npc"},  NPC,                 v.e_addr + 32'd4);
    chk({s, ".busy"}, {31'd0, Fetch_Busy}, {31'd0, v.e_busy});
    @(posedge clk);
    #1;
    chk({s, ".pc"},     PC,                   v.e_pc);
    chk({s, ".ifpc"},   IF_ID_PC,             v.e_ifpc);
    chk({s, ".ifnpc"},  IF_ID_NPC,            v.e_ifpc + 32'd4);
    chk({s, ".instr"},  IF_ID_Instr,          v.e_instr);
    chk({s, ".valid"},  {31'd0, IF_ID_Valid}, {31'd0, v.e_valid});
    chk({s, ".cnt"},    {16'd0, Bubble_Count}, {16'd0, v.e_cnt});
  endtask

  initial begin
    rst        = 1'b1;
    Redirect   = 1'b0;
    Stall      = 1'b0;
    IMem_Ack   = 1'b0;
    PC_Result  = 32'h0;
    IMem_Rdata = 32'h0;

    //             red   stl   ack   pc_res          rdata           req   addr            busy  pc              ifpc            instr           vld   cnt
    // Straight-line fetch, three acks.
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'hA000_3000, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3004, 32'h0000_3000, 32'hA000_3000, 1'b1, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_3008, 32'hA000_3004, 1'b1, 32'h0000_3004, 1'b0, 32'h0000_3008, 32'h0000_3004, 32'hA000_3004, 1'b1, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_300C, 32'hA000_3008, 1'b1, 32'h0000_3008, 1'b0, 32'h0000_300C, 32'h0000_3008, 32'hA000_3008, 1'b1, 16'd0});
    // Ack withheld twice: two bubbles, PC holds.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0000_3010, 32'hBAD0_0000, 1'b1, 32'h0000_300C, 1'b1, 32'h0000_300C, 32'h0000_3008, 32'h0000_0000, 1'b0, 16'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0000_3010, 32'hBAD0_0000, 1'b1, 32'h0000_300C, 1'b1, 32'h0000_300C, 32'h0000_3008, 32'h0000_0000, 1'b0, 16'd2});
    // Ack under stall: word goes to skid, IF/ID holds, PC advances.
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0000_3010, 32'hA000_300C, 1'b1, 32'h0000_300C, 1'b0, 32'h0000_3010, 32'h0000_3008, 32'h0000_0000, 1'b0, 16'd2});
    // Still stalled in hold: no request, nothing moves.
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0000_3014, 32'hBAD0_0001, 1'b0, 32'h0000_3010, 1'b0, 32'h0000_3010, 32'h0000_3008, 32'h0000_0000, 1'b0, 16'd2});
    // Stall drops: skid drains into IF/ID.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0000_3014, 32'hBAD0_0002, 1'b0, 32'h0000_3010, 1'b0, 32'h0000_3010, 32'h0000_300C, 32'hA000_300C, 1'b1, 16'd2});
    // Request resumes at the advanced PC.
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_3014, 32'hA000_3010, 1'b1, 32'h0000_3010, 1'b0, 32'h0000_3014, 32'h0000_3010, 32'hA000_3010, 1'b1, 16'd2});
    // Redirect with ack and stall: flush wins, word dropped.
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h0000_3100, 32'hDEAD_BEEF, 1'b1, 32'h0000_3014, 1'b0, 32'h0000_3100, 32'h0000_3010, 32'h0000_0000, 1'b0, 16'd2});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_3104, 32'hA000_3100, 1'b1, 32'h0000_3100, 1'b0, 32'h0000_3104, 32'h0000_3100, 32'hA000_3100, 1'b1, 16'd2});
    // Fill skid, then redirect while holding: skid is discarded.
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h0000_3108, 32'hA000_3104, 1'b1, 32'h0000_3104, 1'b0, 32'h0000_3108, 32'h0000_3100, 32'hA000_3100, 1'b1, 16'd2});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_3200, 32'hBAD0_0003, 1'b0, 32'h0000_3108, 1'b0, 32'h0000_3200, 32'h0000_3100, 32'h0000_0000, 1'b0, 16'd2});
    // Back in S_REQ at 0x3200: a miss bubbles, then the fetch lands.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0000_3204, 32'hBAD0_0004, 1'b1, 32'h0000_3200, 1'b1, 32'h0000_3200, 32'h0000_3100, 32'h0000_0000, 1'b0, 16'd3});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_3204, 32'hA000_3200, 1'b1, 32'h0000_3200, 1'b0, 32'h0000_3204, 32'h0000_3200, 32'hA000_3200, 1'b1, 16'd3});
    // Miss under stall: no bubble, no count.
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0000_3208, 32'hBAD0_0005, 1'b1, 32'h0000_3204, 1'b1, 32'h0000_3204, 32'h0000_3200, 32'hA000_3200, 1'b1, 16'd3});
    // Redirect with no ack: flush is not counted as a bubble.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0000_3300, 32'hBAD0_0006, 1'b1, 32'h0000_3204, 1'b1, 32'h0000_3300, 32'h0000_3200, 32'h0000_0000, 1'b0, 16'd3});
    // PC wrap-around.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hBAD0_0007, 1'b1, 32'h0000_3300, 1'b1, 32'hFFFF_FFFC, 32'h0000_3200, 32'h0000_0000, 1'b0, 16'd3});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 16'd3});

    // Reset state, no clock edge needed.
    #1;
    chk("rst.pc",    PC,                   32'h0000_3000);
    chk("rst.req",   {31'd0, IMem_Req},    32'd0);
    chk("rst.valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("rst.instr", IF_ID_Instr,          32'h0);
    chk("rst.ifpc",  IF_ID_PC,             32'h0);
    chk("rst.ifnpc", IF_ID_NPC,            32'h4);
    chk("rst.cnt",   {16'd0, Bubble_Count}, 32'd0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset between edges.
    @(posedge clk);
    IMem_Ack = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("arst.pc",    PC,                   32'h0000_3000);
    chk("arst.valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("arst.instr", IF_ID_Instr,          32'h0);
    chk("arst.req",   {31'd0, IMem_Req},    32'd0);
    chk("arst.cnt",   {16'd0, Bubble_Count}, 32'd0);

    // Saturation: 0xFFFF misses fill the counter, one more must not wrap.
    @(negedge clk);
    rst      = 1'b0;
    Redirect = 1'b0;
    Stall    = 1'b0;
    IMem_Ack = 1'b0;
    #1;
    chk("sat.busy", {31'd0, Fetch_Busy}, 32'd1);
    chk("sat.addr", IMem_Addr,           32'h0000_3000);
    for (int n = 0; n < 65535; n++) @(posedge clk);
    #1;
    chk("sat.cnt_full", {16'd0, Bubble_Count}, 32'h0000_FFFF);
    @(posedge clk);
    #1;
    chk("sat.cnt_hold", {16'd0, Bubble_Count}, 32'h0000_FFFF);
    chk("sat.pc",       PC,                    32'h0000_3000);
    chk("sat.valid",    {31'd0, IF_ID_Valid},  32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
